// File: rtl/round_robin_dispatcher.sv
// ---------------------------------------------------------------------------
// round_robin_dispatcher
//
// Purpose:
//    Splits one valid/ready input stream across NUM_OUT consumer lanes in
//    rotating order. Each lane has a one-entry holding register. The lane
//    scan starts at a rotating pointer and skips lanes that cannot take data,
//    so no consumer is starved and no consumer is favoured.
//
// Parameters:
//    NUM_OUT     number of output lanes (1 and up, any value)
//    DATA_WIDTH  width of one data item
//
// Ports:
//    clk_i        clock
//    arst_ni      asynchronous reset, active low
//    data_i       input item
//    valid_i      input item valid
//    ready_o      dispatcher can accept an item this cycle
//    data_o       lane data, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//    valid_o      lane holding register occupied
//    ready_i      lane consumer ready
//    sel_index_o  lane chosen this cycle (meaningful only when ready_o=1)
//
// Build option:
//    ROUND_ROBIN_DISPATCHER_STRICT_EN  when defined, only the lane at the
//    rotating pointer may be loaded (exact cyclic order, a stalled lane
//    blocks the input). When undefined, unavailable lanes are skipped.
// ---------------------------------------------------------------------------
module round_robin_dispatcher #(
   parameter int NUM_OUT    = 4,
   parameter int DATA_WIDTH = 8,
   localparam int IW        = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
   input  logic                          clk_i,
   input  logic                          arst_ni,
   input  logic [DATA_WIDTH-1:0]         data_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   output logic [NUM_OUT*DATA_WIDTH-1:0] data_o,
   output logic [NUM_OUT-1:0]            valid_o,
   input  logic [NUM_OUT-1:0]            ready_i,
   output logic [IW-1:0]                 sel_index_o
);

   logic [IW-1:0]                        rot_q, rot_d;
   logic [NUM_OUT-1:0]                   valid_q, valid_d;
   logic [NUM_OUT-1:0][DATA_WIDTH-1:0]   data_q, data_d;

   logic [NUM_OUT-1:0]                   avail;
   logic [IW-1:0]                        sel;
   logic                                 any_ready;
   logic                                 dispatch;

   // A lane can take a new item when it is empty, or when its consumer is
   // draining it this very cycle (drain and refill happen at the same edge).
   always_comb begin
      avail = ~valid_q | ready_i;
   end

`ifdef ROUND_ROBIN_DISPATCHER_STRICT_EN
   // Strict rotation: the pointer lane is the only candidate, so the input
   // waits whenever that lane is full and stalled. The loop compares against
   // every lane instead of indexing, which keeps NUM_OUT=1 clean.
   always_comb begin
      sel       = rot_q;
      any_ready = 1'b0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (k == int'(rot_q)) begin
            any_ready = avail[k];
         end
      end
   end
`else
   // Skipping rotation: walk the lanes from the pointer upward with wrap.
   // The walk runs from the farthest offset back to offset 0 so that the
   // last hit, which is the one kept, is the lane closest to the pointer.
   // The wrap is a subtraction rather than a bit mask so non power-of-two
   // lane counts never select a lane that does not exist.
   always_comb begin
      int idx;
      idx       = 0;
      sel       = rot_q;
      any_ready = 1'b0;
      for (int i = NUM_OUT - 1; i >= 0; i--) begin
         idx = int'(rot_q) + i;
         if (idx >= NUM_OUT) begin
            idx = idx - NUM_OUT;
         end
         if (avail[idx]) begin
            sel       = IW'(idx);
            any_ready = 1'b1;
         end
      end
   end
`endif

   // While reset is held the outputs must read as idle, even though every
   // lane looks available, so the handshake outputs are gated with arst_ni.
   always_comb begin
      ready_o     = arst_ni & any_ready;
      sel_index_o = arst_ni ? sel : '0;
      dispatch    = valid_i & ready_o;
      valid_o     = valid_q;
      data_o      = data_q;
   end

   // Next-state: drains clear lanes first, then a dispatch loads the selected
   // lane, which overrides a same-cycle drain of that lane. Data registers
   // only change on a load. The pointer moves to the lane after the one just
   // loaded, wrapping explicitly from NUM_OUT-1 to 0.
   always_comb begin
      valid_d = valid_q & ~ready_i;
      data_d  = data_q;
      rot_d   = rot_q;
      if (dispatch) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (IW'(k) == sel) begin
               valid_d[k] = 1'b1;
               data_d[k]  = data_i;
            end
         end
         if (sel == IW'(NUM_OUT - 1)) begin
            rot_d = '0;
         end else begin
            rot_d = sel + IW'(1);
         end
      end
   end

   // State registers; reset throws away every held item and points the
   // rotation back at lane 0.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         rot_q   <= '0;
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         rot_q   <= rot_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule
